// File: rtl/regfile_param.sv
// Parametrised two-read/one-write register file with per-byte write enables,
// an optional hardwired zero entry, optional write-to-read bypass and a
// sequential clear engine that zeroes every entry after reset or on request.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   write_i        write request
//   write_addr_i   write address
//   write_data_i   write data
//   write_be_i     byte enables, bit i covers data bits [8i+7:8i]
//   read_addr1_i   read port 1 address
//   read_addr2_i   read port 2 address
//   read_data1_o   read port 1 data (combinational)
//   read_data2_o   read port 2 data (combinational)
//   clear_i        one-cycle pulse that starts a zero sweep
//   ready_o        registered, high once the sweep has finished
module regfile_param #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  write_i,
  input  logic [ADDR_W-1:0]     write_addr_i,
  input  logic [DATA_W-1:0]     write_data_i,
  input  logic [DATA_W/8-1:0]   write_be_i,
  input  logic [ADDR_W-1:0]     read_addr1_i,
  input  logic [ADDR_W-1:0]     read_addr2_i,
  output logic [DATA_W-1:0]     read_data1_o,
  output logic [DATA_W-1:0]     read_data2_o,
  input  logic                  clear_i,
  output logic                  ready_o
);

  localparam int unsigned DEPTH  = 1 << ADDR_W;
  localparam int unsigned NBYTES = DATA_W / 8;
  localparam bit          ZR     = (ZERO_REG != 0);
  localparam bit          BP     = (BYPASS != 0);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   clr_idx_q, clr_idx_d;
  logic                ready_q, ready_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic                wr_en;
  logic                wr_to_zero;
  logic [DATA_W-1:0]   be_mask;
  logic [DATA_W-1:0]   wr_merged;

  // Expand byte enables into a bit mask.
  always_comb begin
    be_mask = '0;
    for (int i = 0; i < NBYTES; i++) begin
      be_mask[8*i +: 8] = {8{write_be_i[i]}};
    end
  end

  // Effective write: RUN only, clear has priority over write.
  always_comb begin
    wr_en      = (state_q == ST_RUN) && write_i && !clear_i;
    wr_to_zero = ZR && (write_addr_i == '0);
    wr_merged  = (write_data_i & be_mask) | (mem_q[write_addr_i] & ~be_mask);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_CLEAR;
      clr_idx_q <= '0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      ready_q   <= ready_d;
    end
  end

  // Next-state logic: sweep all entries, then run until a clear request.
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    ready_d   = ready_q;
    unique case (state_q)
      ST_CLEAR: begin
        // Counter wraps to 0 naturally on the last entry.
        clr_idx_d = clr_idx_q + ADDR_W'(1);
        if (clr_idx_q == ADDR_W'(DEPTH - 1)) begin
          state_d = ST_RUN;
          ready_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (clear_i) begin
          state_d   = ST_CLEAR;
          clr_idx_d = '0;
          ready_d   = 1'b0;
        end
      end
      default: begin
        state_d   = ST_CLEAR;
        clr_idx_d = '0;
        ready_d   = 1'b0;
      end
    endcase
  end

  // Storage array; not reset, zeroed by the sweep instead.
  always_ff @(posedge clk) begin
    if (state_q == ST_CLEAR) begin
      mem_q[clr_idx_q] <= '0;
    end else if (wr_en && !wr_to_zero) begin
      mem_q[write_addr_i] <= wr_merged;
    end
  end

  // Read mux: sweep forces zero, zero entry beats bypass, bypass beats array.
  function automatic logic [DATA_W-1:0] read_port(
    input logic [ADDR_W-1:0] addr,
    input logic              in_run,
    input logic              wr_hit,
    input logic [DATA_W-1:0] byp_data,
    input logic [DATA_W-1:0] stored
  );
    logic [DATA_W-1:0] r;
    if (!in_run) begin
      r = '0;
    end else if (ZR && (addr == '0)) begin
      r = '0;
    end else if (BP && wr_hit) begin
      r = byp_data;
    end else begin
      r = stored;
    end
    return r;
  endfunction

  always_comb begin
    read_data1_o = read_port(read_addr1_i, state_q == ST_RUN,
                             wr_en && (read_addr1_i == write_addr_i),
                             wr_merged, mem_q[read_addr1_i]);
    read_data2_o = read_port(read_addr2_i, state_q == ST_RUN,
                             wr_en && (read_addr2_i == write_addr_i),
                             wr_merged, mem_q[read_addr2_i]);
  end

  assign ready_o = ready_q;

endmodule

// File: tb/tb_regfile_param.sv
// Bench for regfile_param: a default build (zero entry + bypass) and a plain
// build (no zero entry, no bypass) share all inputs and are checked against
// an array-based reference model.
module tb_regfile_param;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        write = 1'b0;
  logic [4:0]  wa = '0;
  logic [31:0] wd = '0;
  logic [3:0]  be = '0;
  logic [4:0]  ra1 = '0;
  logic [4:0]  ra2 = '0;
  logic        clear = 1'b0;

  logic [31:0] rd1_a, rd2_a, rd1_b, rd2_b;
  logic        rdy_a, rdy_b;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state.
  bit          mdl_run = 1'b0;
  int          sweep = 0;
  logic [31:0] m0 [32];
  logic [31:0] m1 [32];

  always #5 clk = ~clk;

  regfile_param u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .write_i(write), .write_addr_i(wa), .write_data_i(wd), .write_be_i(be),
    .read_addr1_i(ra1), .read_addr2_i(ra2),
    .read_data1_o(rd1_a), .read_data2_o(rd2_a),
    .clear_i(clear), .ready_o(rdy_a)
  );

  regfile_param #(.ZERO_REG(0), .BYPASS(0)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .write_i(write), .write_addr_i(wa), .write_data_i(wd), .write_be_i(be),
    .read_addr1_i(ra1), .read_addr2_i(ra2),
    .read_data1_o(rd1_b), .read_data2_o(rd2_b),
    .clear_i(clear), .ready_o(rdy_b)
  );

  function automatic logic [31:0] merge(input logic [31:0] old,
                                        input logic [31:0] d,
                                        input logic [3:0] b);
    logic [31:0] r = old;
    for (int i = 0; i < 4; i++) if (b[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] exp_rd(input bit plain, input logic [4:0] a);
    if (!mdl_run) return 32'h0;
    if (plain) return m1[a];
    if (a == 5'd0) return 32'h0;
    if (write && !clear && a == wa) return merge(m0[a], wd, be);
    return m0[a];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("ready_a", 32'(rdy_a), 32'(mdl_run));
    chk("ready_b", 32'(rdy_b), 32'(mdl_run));
    chk("rd1_a", rd1_a, exp_rd(1'b0, ra1));
    chk("rd2_a", rd2_a, exp_rd(1'b0, ra2));
    chk("rd1_b", rd1_b, exp_rd(1'b1, ra1));
    chk("rd2_b", rd2_b, exp_rd(1'b1, ra2));
  endtask

  // Model effect of one rising edge with the current inputs.
  task automatic model_edge();
    if (!rst_n) return;
    if (!mdl_run) begin
      sweep++;
      if (sweep == 32) begin
        mdl_run = 1'b1;
        sweep   = 0;
        for (int i = 0; i < 32; i++) begin
          m0[i] = 32'h0;
          m1[i] = 32'h0;
        end
      end
    end else if (clear) begin
      mdl_run = 1'b0;
      sweep   = 0;
    end else if (write) begin
      if (wa != 5'd0) m0[wa] = merge(m0[wa], wd, be);
      m1[wa] = merge(m1[wa], wd, be);
    end
  endtask

  // Check outputs mid-cycle, then take one edge.
  task automatic tick();
    @(negedge clk);
    check_all();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic reset_assert();
    rst_n   = 1'b0;
    mdl_run = 1'b0;
    sweep   = 0;
  endtask

  initial begin
    #1;
    reset_assert();
    #1;
    chk("reset_ready", 32'(rdy_a), 32'h0);
    tick();
    tick();
    rst_n = 1'b1;

    // Sweep after reset: writes to 9 and clear must be ignored.
    for (int k = 0; k < 32; k++) begin
      write = 1'b1; wa = 5'd9; wd = 32'hA5A5A5A5; be = 4'hF;
      ra1 = 5'd9; ra2 = 5'(k);
      clear = (k == 3);
      tick();
    end
    write = 1'b0; clear = 1'b0;
    #1;
    chk("ready_after_32", 32'(rdy_a), 32'h1);
    chk("addr9_after_sweep", rd1_a, 32'h0);

    // Every address reads zero on both ports.
    for (int a = 0; a < 32; a++) begin
      ra1 = 5'(a); ra2 = 5'(31 - a);
      tick();
    end

    // Byte-enable merge.
    write = 1'b1; wa = 5'd5; wd = 32'hDEADBEEF; be = 4'hF; ra1 = 5'd5; ra2 = 5'd5;
    tick();
    wd = 32'h11223344; be = 4'b0101;
    tick();
    write = 1'b0;
    #1;
    chk("be_merge_a", rd1_a, 32'hDE22BE44);
    chk("be_merge_b", rd2_b, 32'hDE22BE44);
    tick();

    // Bypass vs no bypass.
    write = 1'b1; wa = 5'd7; wd = 32'hCAFEF00D; be = 4'hF; ra1 = 5'd7; ra2 = 5'd5;
    #1;
    chk("bypass_same_cycle", rd1_a, 32'hCAFEF00D);
    chk("nobypass_same_cycle", rd1_b, 32'h0);
    tick();
    write = 1'b0;
    #1;
    chk("nobypass_next_cycle", rd1_b, 32'hCAFEF00D);

    // Zero register; neighbour keeps its value.
    write = 1'b1; wa = 5'd1; wd = 32'h01020304; be = 4'hF;
    tick();
    wa = 5'd0; wd = 32'hFFFFFFFF; ra1 = 5'd0; ra2 = 5'd0;
    #1;
    chk("zero_bypass_blocked", rd1_a, 32'h0);
    tick();
    write = 1'b0;
    #1;
    chk("zero_p1", rd1_a, 32'h0);
    chk("zero_p2", rd2_a, 32'h0);
    chk("plain_addr0", rd1_b, 32'hFFFFFFFF);
    ra2 = 5'd1;
    #1;
    chk("neighbour", rd2_a, 32'h01020304);
    tick();

    // Clear with simultaneous write: write dropped, 32-edge sweep.
    write = 1'b1; wa = 5'd3; wd = 32'h12345678; be = 4'hF; clear = 1'b1;
    ra1 = 5'd3; ra2 = 5'd5;
    tick();
    write = 1'b0; clear = 1'b0;
    for (int k = 0; k < 32; k++) tick();
    chk("clear_ready", 32'(rdy_a), 32'h1);
    chk("clear_addr3", rd1_a, 32'h0);
    chk("clear_addr5", rd2_b, 32'h0);

    // Randomised traffic.
    for (int k = 0; k < 400; k++) begin
      write = 1'($urandom_range(0, 1));
      wa    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      wd    = $urandom;
      be    = 4'($urandom);
      ra1   = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom);
      ra2   = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom);
      clear = ($urandom_range(0, 99) == 0);
      tick();
    end
    write = 1'b0; clear = 1'b0;
    for (int k = 0; k < 34; k++) tick();

    // Reset at sweep index 16 restarts the full sweep.
    clear = 1'b1;
    tick();
    clear = 1'b0;
    for (int k = 0; k < 16; k++) tick();
    reset_assert();
    #1;
    chk("midsweep_rst_ready", 32'(rdy_a), 32'h0);
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 31; k++) tick();
    chk("before_edge32_ready", 32'(rdy_a), 32'h0);
    tick();
    chk("after_edge32_ready", 32'(rdy_a), 32'h1);
    tick();

    // Reset mid-run also restarts the sweep.
    write = 1'b1; wa = 5'd12; wd = 32'h5A5A5A5A; be = 4'hF; ra1 = 5'd12;
    tick();
    write = 1'b0;
    reset_assert();
    #1;
    chk("midrun_rst_ready", 32'(rdy_a), 32'h0);
    chk("midrun_rst_read", rd1_a, 32'h0);
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 33; k++) tick();
    chk("midrun_rst_addr12", rd1_b, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
